// File: rtl/min_max_comparator_bank_if.sv
// Purpose    : bus bundle for min_max_comparator_bank (config port, vector input, results, hit counters).
// Latency    : n/a (wires only).
// Backpressure: none; the bank accepts one vector per cycle and results carry no ready.
// Ports (master = GC driver side, slave = comparator bank side):
//   cfg_we/cfg_addr/cfg_sel/cfg_wdata : channel register write port
//   in_valid/ivar                     : iteration vector, dim d at ivar[d*W +: W]
//   out_valid/c_out/match_all         : registered per-channel conditions and their AND
//   cnt_clr/hit_cnt                   : hit counter clear and values (active only with MINMAX_HIT_COUNT_EN)
interface min_max_comparator_bank_if #(
  parameter int ITERATION_VARIABLE_WIDTH = 16,
  parameter int NUM_DIMS                 = 3,
  parameter int NUM_CH                   = 8,
  parameter int CH_AW                    = 3,
  parameter int CNT_WIDTH                = 16
);
  logic                                         cfg_we;
  logic [CH_AW-1:0]                             cfg_addr;
  logic [1:0]                                   cfg_sel;
  logic [ITERATION_VARIABLE_WIDTH-1:0]          cfg_wdata;
  logic                                         in_valid;
  logic [NUM_DIMS*ITERATION_VARIABLE_WIDTH-1:0] ivar;
  logic                                         out_valid;
  logic [NUM_CH-1:0]                            c_out;
  logic                                         match_all;
  logic                                         cnt_clr;
  logic [NUM_CH*CNT_WIDTH-1:0]                  hit_cnt;

  modport master (
    output cfg_we, cfg_addr, cfg_sel, cfg_wdata,
    output in_valid, ivar,
    output cnt_clr,
    input  out_valid, c_out, match_all,
    input  hit_cnt
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_sel, cfg_wdata,
    input  in_valid, ivar,
    input  cnt_clr,
    output out_valid, c_out, match_all,
    output hit_cnt
  );
endinterface

// File: rtl/min_max_comparator_bank.sv
// Purpose    : bank of NUM_CH signed range comparators, each with programmable min/max, dim select and mode.
// Latency    : 2 cycles, in_valid launched at edge N gives out_valid with results after edge N+2; 1 vector/cycle.
// Backpressure: none; every valid vector is accepted and its result is presented exactly once.
// Ports:
//   clk, rst : clock and asynchronous active-high reset (clears config, pipeline valids, counters)
//   bus      : min_max_comparator_bank_if.slave (config write, vector in, c_out/match_all out, hit counters)
// Optional feature: define MINMAX_HIT_COUNT_EN to build saturating per-channel hit counters;
// without it hit_cnt is tied to zero and cnt_clr is ignored.
module min_max_comparator_bank #(
  parameter int ITERATION_VARIABLE_WIDTH = 16,
  parameter int NUM_DIMS                 = 3,
  parameter int NUM_CH                   = 8,
  parameter int CH_AW                    = 3,
  parameter int DIM_AW                   = 2,
  parameter int CNT_WIDTH                = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  min_max_comparator_bank_if.slave      bus
);

  localparam int W = ITERATION_VARIABLE_WIDTH;

  typedef enum logic [1:0] {
    MODE_INSIDE  = 2'd0,
    MODE_OUTSIDE = 2'd1,
    MODE_BYPASS  = 2'd2,
    MODE_OFF     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    FIELD_MIN  = 2'd0,
    FIELD_MAX  = 2'd1,
    FIELD_CTRL = 2'd2,
    FIELD_RSVD = 2'd3
  } field_e;

  field_e cfg_field;
  assign cfg_field = field_e'(bus.cfg_sel);

  // Combinational per-channel result for the vector currently on the input,
  // evaluated against the configuration registers as they stand this cycle.
  logic [NUM_CH-1:0] hit;

  // Stage 1 and stage 2 pipeline state.
  logic              v1_q;
  logic [NUM_CH-1:0] hit_q;
  logic              out_valid_q;
  logic [NUM_CH-1:0] c_out_q;
  logic              match_all_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic signed [W-1:0] min_q;
    logic signed [W-1:0] max_q;
    logic [DIM_AW-1:0]   dim_q;
    mode_e               mode_q;
    logic                wr_this;
    logic signed [W-1:0] v;
    logic                hit_c;

    // Exact address match only: addresses at or above NUM_CH match no channel,
    // so out-of-range writes fall on the floor without aliasing.
    assign wr_this = bus.cfg_we && (bus.cfg_addr == CH_AW'(c));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        min_q  <= '0;
        max_q  <= '0;
        dim_q  <= '0;
        mode_q <= MODE_BYPASS;
      end else if (wr_this) begin
        case (cfg_field)
          FIELD_MIN:  min_q <= bus.cfg_wdata;
          FIELD_MAX:  max_q <= bus.cfg_wdata;
          FIELD_CTRL: begin
            mode_q <= mode_e'(bus.cfg_wdata[1:0]);
            dim_q  <= bus.cfg_wdata[DIM_AW+1:2];
          end
          default: ;
        endcase
      end
    end

    // Dimension mux; any dim_sel without a matching dimension falls back to dim 0.
    always_comb begin
      v = bus.ivar[0 +: W];
      for (int d = 1; d < NUM_DIMS; d++) begin
        if (dim_q == DIM_AW'(d)) begin
          v = bus.ivar[d*W +: W];
        end
      end
    end

    // With min > max the inside window is empty and the outside window covers
    // everything, which falls out of these expressions without special-casing.
    always_comb begin
      hit_c = 1'b0;
      case (mode_q)
        MODE_INSIDE:  hit_c = (v >= min_q) && (v <= max_q);
        MODE_OUTSIDE: hit_c = (v < min_q) || (v > max_q);
        MODE_BYPASS:  hit_c = 1'b1;
        MODE_OFF:     hit_c = 1'b0;
        default:      hit_c = 1'b0;
      endcase
    end

    assign hit[c] = hit_c;

`ifdef MINMAX_HIT_COUNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;

    // Counts on the same edge that stage 2 loads this channel's result.
    // Clear wins over a coincident increment; the counter sticks at all ones.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else if (bus.cnt_clr) begin
        cnt_q <= '0;
      end else if (v1_q && hit_q[c] && (cnt_q != {CNT_WIDTH{1'b1}})) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
    end

    assign bus.hit_cnt[c*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
`endif
  end

`ifndef MINMAX_HIT_COUNT_EN
  logic unused_cnt_clr;
  assign unused_cnt_clr = bus.cnt_clr;
  assign bus.hit_cnt    = '0;
`endif

  // Stage 1: capture the comparison results of an accepted vector.
  // hit_q only loads on valid cycles so idle cycles cost no toggling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q  <= 1'b0;
      hit_q <= '1;
    end else begin
      v1_q <= bus.in_valid;
      if (bus.in_valid) begin
        hit_q <= hit;
      end
    end
  end

  // Stage 2: present results. c_out/match_all hold the last valid result
  // between vectors; reset values match an all-bypass configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      c_out_q     <= '1;
      match_all_q <= 1'b1;
    end else begin
      out_valid_q <= v1_q;
      if (v1_q) begin
        c_out_q     <= hit_q;
        match_all_q <= &hit_q;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.c_out     = c_out_q;
  assign bus.match_all = match_all_q;

endmodule

// File: tb/tb_min_max_comparator_bank.sv
// Purpose    : self-checking bench for min_max_comparator_bank with a cycle-indexed behavioural model.
// Latency    : results expected two cycles after the cycle a vector is driven.
// Backpressure: none exercised; the DUT has no ready.
module tb_min_max_comparator_bank;
  localparam int W     = 16;
  localparam int ND    = 3;
  localparam int NCH   = 8;
  localparam int CHAW  = 4;   // wide enough to present out-of-range address 9
  localparam int DAW   = 2;
  localparam int CW    = 4;
  localparam int DEPTH = 2048;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  min_max_comparator_bank_if #(
    .ITERATION_VARIABLE_WIDTH(W), .NUM_DIMS(ND), .NUM_CH(NCH), .CH_AW(CHAW), .CNT_WIDTH(CW)
  ) bus ();

  min_max_comparator_bank #(
    .ITERATION_VARIABLE_WIDTH(W), .NUM_DIMS(ND), .NUM_CH(NCH),
    .CH_AW(CHAW), .DIM_AW(DAW), .CNT_WIDTH(CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs   = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // Model configuration and counters, plain integers.
  int m_min [NCH];
  int m_max [NCH];
  int m_dim [NCH];
  int m_mode[NCH];
  int m_cnt [NCH];

  // Expectations indexed by the cycle number at which the DUT output shows them.
  bit             exp_v   [DEPTH];
  logic [NCH-1:0] exp_c   [DEPTH];
  bit             clr_at  [DEPTH];
  bit             lit_en  [DEPTH];
  logic [NCH-1:0] lit_mask[DEPTH];
  logic [NCH-1:0] lit_val [DEPTH];
  bit             litm_en [DEPTH];
  bit             litm_val[DEPTH];
  bit             litk_en [DEPTH];
  int             litk_val[DEPTH];

  logic [NCH-1:0] last_c;
  bit             last_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic bit model_hit(input int ch, input int d0, input int d1, input int d2);
    int dims[3];
    int v;
    dims = '{d0, d1, d2};
    v = (m_dim[ch] < ND) ? dims[m_dim[ch]] : dims[0];
    case (m_mode[ch])
      0:       return (v >= m_min[ch]) && (v <= m_max[ch]);
      1:       return (v < m_min[ch]) || (v > m_max[ch]);
      2:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [NCH*CW-1:0] model_cnt_vec();
    logic [NCH*CW-1:0] r;
    r = '0;
    for (int ch = 0; ch < NCH; ch++) r[ch*CW +: CW] = CW'(m_cnt[ch]);
    return r;
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < NCH; ch++) begin
      m_min[ch] = 0; m_max[ch] = 0; m_dim[ch] = 0; m_mode[ch] = 2; m_cnt[ch] = 0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp_v[i] = 1'b0; clr_at[i] = 1'b0; lit_en[i] = 1'b0; litm_en[i] = 1'b0; litk_en[i] = 1'b0;
    end
    last_c = '1;
    last_m = 1'b1;
  endtask

  task automatic model_write(input int addr, input int sel, input int data);
    if (addr < NCH) begin
      case (sel)
        0: m_min[addr] = int'($signed(16'(data)));
        1: m_max[addr] = int'($signed(16'(data)));
        2: begin m_mode[addr] = data & 3; m_dim[addr] = (data >> 2) & 3; end
        default: ;
      endcase
    end
  endtask

  // One input cycle. Expectations use the model config before this cycle's write.
  task automatic drive(input bit vld, input int d0, input int d1, input int d2,
                       input bit we, input int addr, input int sel, input int data, input bit clr);
    @(posedge clk); #1;
    if (cyc >= DEPTH - 4) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, DEPTH - 4);
      $fatal(1);
    end
    bus.in_valid  = vld;
    bus.ivar      = {16'(d2), 16'(d1), 16'(d0)};
    bus.cfg_we    = we;
    bus.cfg_addr  = CHAW'(addr);
    bus.cfg_sel   = 2'(sel);
    bus.cfg_wdata = W'(data);
    bus.cnt_clr   = clr;
    if (vld) begin
      exp_v[cyc+2] = 1'b1;
      for (int ch = 0; ch < NCH; ch++) exp_c[cyc+2][ch] = model_hit(ch, d0, d1, d2);
    end
    if (clr) clr_at[cyc+1] = 1'b1;
    if (we) model_write(addr, sel, data);
  endtask

  task automatic cfg(input int addr, input int sel, input int data);
    drive(1'b0, 0, 0, 0, 1'b1, addr, sel, data, 1'b0);
  endtask
  task automatic vec(input int d0, input int d1, input int d2);
    drive(1'b1, d0, d1, d2, 1'b0, 0, 0, 0, 1'b0);
  endtask
  task automatic idle();
    drive(1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b0);
  endtask
  task automatic clr_cycle();
    drive(1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b1);
  endtask

  // Hand-computed expectations for the vector just driven.
  task automatic lit(input logic [NCH-1:0] mask, input logic [NCH-1:0] val);
    lit_en[cyc+2] = 1'b1; lit_mask[cyc+2] = mask; lit_val[cyc+2] = val;
  endtask
  task automatic litm(input bit val);
    litm_en[cyc+2] = 1'b1; litm_val[cyc+2] = val;
  endtask
  task automatic litk(input int off, input int val);
    litk_en[cyc+off] = 1'b1; litk_val[cyc+off] = val;
  endtask

  always @(negedge clk) begin : cmp
    int t;
    if (rst) begin
      last_c = '1;
      last_m = 1'b1;
      for (int ch = 0; ch < NCH; ch++) m_cnt[ch] = 0;
    end else if (chk_on) begin
      t = cyc;
      if (clr_at[t]) begin
        for (int ch = 0; ch < NCH; ch++) m_cnt[ch] = 0;
      end else if (exp_v[t]) begin
`ifdef MINMAX_HIT_COUNT_EN
        for (int ch = 0; ch < NCH; ch++)
          if (exp_c[t][ch] && m_cnt[ch] < CMAX) m_cnt[ch]++;
`endif
      end
      if (exp_v[t]) begin
        last_c = exp_c[t];
        last_m = &exp_c[t];
      end
      check("out_valid", 64'(bus.out_valid), 64'(exp_v[t]));
      check("c_out", 64'(bus.c_out), 64'(last_c));
      check("match_all", 64'(bus.match_all), 64'(last_m));
      check("hit_cnt", 64'(bus.hit_cnt), 64'(model_cnt_vec()));
      if (lit_en[t])  check("c_out_literal", 64'(bus.c_out & lit_mask[t]), 64'(lit_val[t] & lit_mask[t]));
      if (litm_en[t]) check("match_all_literal", 64'(bus.match_all), 64'(litm_val[t]));
      if (litk_en[t]) check("hit_cnt0_literal", 64'(bus.hit_cnt[CW-1:0]), 64'(litk_val[t]));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_sel = '0; bus.cfg_wdata = '0;
    bus.in_valid = 1'b0; bus.ivar = '0; bus.cnt_clr = 1'b0;
    model_reset();

    // Reset state.
    #12;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_c_out", 64'(bus.c_out), 64'hFF);
    check("rst_match_all", 64'(bus.match_all), 64'd1);
    check("rst_hit_cnt", 64'(bus.hit_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;

    // Unconfigured bank: all bypass.
    vec(5, -3, 7); lit(8'hFF, 8'hFF); litm(1'b1);
    idle();

    // ch0 inside [-2,4] on dim 1, back-to-back vectors.
    cfg(0, 0, -2); cfg(0, 1, 4); cfg(0, 2, (1 << 2) | 0);
    vec(0, -3, 0); lit(8'h01, 8'h00);
    vec(0, -2, 0); lit(8'h01, 8'h01);
    vec(0,  4, 0); lit(8'h01, 8'h01);
    vec(0,  5, 0); lit(8'h01, 8'h00);

    // ch1 outside [10,20] on dim 2, then off.
    cfg(1, 0, 10); cfg(1, 1, 20); cfg(1, 2, (2 << 2) | 1);
    vec(0, 0,  9); lit(8'h02, 8'h02);
    vec(0, 0, 10); lit(8'h02, 8'h00);
    vec(0, 0, 21); lit(8'h02, 8'h02);
    cfg(1, 2, (2 << 2) | 3);
    vec(0, 0, 0); lit(8'h02, 8'h00); litm(1'b0);

    // Config write coincident with a vector uses the old max.
    drive(1'b1, 0, 8, 0, 1'b1, 0, 1, 10, 1'b0); lit(8'h01, 8'h00);
    vec(0, 8, 0); lit(8'h01, 8'h01);

    // Out-of-range address must not alias onto ch1.
    cfg(1, 2, 2);
    cfg(9, 2, 3);
    vec(0, 8, 0); lit(8'hFF, 8'hFF); litm(1'b1);

    // dim_sel beyond NUM_DIMS and inverted windows.
    cfg(2, 2, (3 << 2) | 0);
    cfg(3, 0, 5); cfg(3, 1, 1); cfg(3, 2, 0);
    cfg(4, 0, 5); cfg(4, 1, 1); cfg(4, 2, 1);
    vec(0, 8, 0); lit(8'h1C, 8'h14);
    vec(1, 8, 0); lit(8'h1C, 8'h10);

    // Hit counters on ch0 (bypass).
    cfg(0, 2, 2);
    clr_cycle();
    for (int i = 0; i < 20; i++) vec(0, 0, 0);
`ifdef MINMAX_HIT_COUNT_EN
    litk(2, 15);
`endif
    vec(0, 0, 0);
    clr_cycle();
`ifdef MINMAX_HIT_COUNT_EN
    litk(1, 0);
`endif
    vec(0, 0, 0);
`ifdef MINMAX_HIT_COUNT_EN
    litk(2, 1);
`endif
    idle(); idle();

    // Reset while results are streaming.
    cfg(0, 2, (1 << 2) | 0);
    vec(0, 20, 0); vec(0, 0, 0); vec(0, 20, 0); vec(0, 20, 0);
    #3;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_c_out", 64'(bus.c_out), 64'hFF);
    check("midrst_match_all", 64'(bus.match_all), 64'd1);
    check("midrst_hit_cnt", 64'(bus.hit_cnt), 64'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // ch0 must be back in bypass: dim1=20 now hits.
    vec(0, 20, 0); lit(8'hFF, 8'hFF); litm(1'b1);
    idle(); idle(); idle(); idle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
